an37_grid_seq_decoder: RTL and testbench

//  Parametrised sequential successor to the combinational 4x4 AN-code grid decoder.
//  - Accepts one ROWS x COLS block of AN codewords (A=37) per valid/ready transaction.
//  - Per lane: Barrett reduction gives quotient q and residue r.
//  - Every erroneous lane (r!=0) is fixed in turn by ONE shared syndrome corrector, up to MAX_FIX lanes.
//  - Sits between the storage read port and the message consumer.

---
 rtl/an37_grid_pkg.sv | 66 ++++++
 rtl/an37_grid_seq_decoder_if.sv | 34 +++
 rtl/an_barrett_lane.sv | 34 +++
 rtl/an37_grid_seq_decoder.sv | 174 +++++++++++++++++
 tb/tb_an37_grid_seq_decoder.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/an37_grid_pkg.sv
// Shared constants, state type and syndrome table for the AN-37 grid decoder.
package an37_grid_pkg;

  localparam int A     = 37;
  localparam int CW_W  = 18;
  localparam int MSG_W = 13;
  localparam int RES_W = 6;

  typedef enum logic [1:0] {IDLE, LOAD, FIX, DONE} state_t;

  typedef struct packed {
    logic       neg;
    logic [4:0] k;
  } syn_t;

  // residue -> error e = (neg ? -1 : +1) * 2^k; 2 has order 36 mod 37 so every nonzero residue appears
  function automatic syn_t syn_lookup(input logic [RES_W-1:0] r);
    syn_t s;
    s = '0;
    case (r)
      6'd1:  s = {1'b0, 5'd0};
      6'd2:  s = {1'b0, 5'd1};
      6'd3:  s = {1'b1, 5'd8};
      6'd4:  s = {1'b0, 5'd2};
      6'd5:  s = {1'b1, 5'd5};
      6'd6:  s = {1'b1, 5'd9};
      6'd7:  s = {1'b1, 5'd14};
      6'd8:  s = {1'b0, 5'd3};
      6'd9:  s = {1'b0, 5'd16};
      6'd10: s = {1'b1, 5'd6};
      6'd11: s = {1'b1, 5'd12};
      6'd12: s = {1'b1, 5'd10};
      6'd13: s = {1'b0, 5'd11};
      6'd14: s = {1'b1, 5'd15};
      6'd15: s = {1'b0, 5'd13};
      6'd16: s = {1'b0, 5'd4};
      6'd17: s = {1'b0, 5'd7};
      6'd18: s = {1'b0, 5'd17};
      6'd19: s = {1'b1, 5'd17};
      6'd20: s = {1'b1, 5'd7};
      6'd21: s = {1'b1, 5'd4};
      6'd22: s = {1'b1, 5'd13};
      6'd23: s = {1'b0, 5'd15};
      6'd24: s = {1'b1, 5'd11};
      6'd25: s = {1'b0, 5'd10};
      6'd26: s = {1'b0, 5'd12};
      6'd27: s = {1'b0, 5'd6};
      6'd28: s = {1'b1, 5'd16};
      6'd29: s = {1'b1, 5'd3};
      6'd30: s = {1'b0, 5'd14};
      6'd31: s = {1'b0, 5'd9};
      6'd32: s = {1'b0, 5'd5};
      6'd33: s = {1'b1, 5'd2};
      6'd34: s = {1'b0, 5'd8};
      6'd35: s = {1'b1, 5'd1};
      6'd36: s = {1'b1, 5'd0};
      default: s = '0;
    endcase
    return s;
  endfunction

  function automatic int lane_idx(input int row, input int col, input int cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/an37_grid_seq_decoder_if.sv
// Block-in / result-out handshake bundle of the AN-37 grid decoder.
interface an37_grid_seq_decoder_if
  import an37_grid_pkg::*;
#(
  parameter int ROWS = 4,
  parameter int COLS = 4
) ();
  localparam int N     = ROWS * COLS;
  localparam int CNT_W = $clog2(N + 1);

  logic               in_valid;
  logic               in_ready;
  logic [N*CW_W-1:0]  in_cw;
  logic               out_valid;
  logic               out_ready;
  logic [N*MSG_W-1:0] out_msg;
  logic [N-1:0]       out_err_map;
  logic [ROWS-1:0]    out_row_err;
  logic [COLS-1:0]    out_col_err;
  logic [CNT_W-1:0]   out_fix_cnt;
  logic               out_uncorr;

  modport master (
    output in_valid, in_cw, out_ready,
    input  in_ready, out_valid, out_msg, out_err_map, out_row_err,
           out_col_err, out_fix_cnt, out_uncorr
  );

  modport slave (
    input  in_valid, in_cw, out_ready,
    output in_ready, out_valid, out_msg, out_err_map, out_row_err,
           out_col_err, out_fix_cnt, out_uncorr
  );
endinterface

// File: rtl/an_barrett_lane.sv
// Combinational Barrett division of one codeword by A: quotient q, residue r.
module an_barrett_lane #(
  parameter int A     = 37,
  parameter int CW_W  = 18,
  parameter int MSG_W = 13,
  parameter int RES_W = 6
) (
  input  logic [CW_W-1:0]  cw,
  output logic [MSG_W-1:0] q,
  output logic [RES_W-1:0] r
);
  // With a 2*CW_W-bit reciprocal the estimate is at most one below the true quotient
  localparam int S = 2 * CW_W;
  localparam logic [S-1:0] M = S'((64'd1 << S) / A);

  logic [S+CW_W-1:0] prod;
  logic [CW_W-1:0]   q_est;
  logic [CW_W-1:0]   q_times_a;
  logic [CW_W:0]     rem;

  always_comb begin
    prod      = (S+CW_W)'(M) * (S+CW_W)'(cw);
    q_est     = prod[S +: CW_W];
    q_times_a = q_est * CW_W'(A);
    rem       = {1'b0, cw} - {1'b0, q_times_a};
    if (rem >= (CW_W+1)'(A)) begin
      q = MSG_W'(q_est + CW_W'(1));
      r = RES_W'(rem - (CW_W+1)'(A));
    end else begin
      q = MSG_W'(q_est);
      r = RES_W'(rem);
    end
  end
endmodule

// File: rtl/an37_grid_seq_decoder.sv
// Sequential AN-37 grid decoder: per-lane Barrett split, then one shared single-error corrector.
// Define AN37_GRID_RANGE_CHECK_EN to reject corrections whose cw' leaves [0, 2^CW_W-1].
module an37_grid_seq_decoder
  import an37_grid_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MAX_FIX = 2
) (
  input logic clk,
  input logic rst_n,
  an37_grid_seq_decoder_if.slave bus
);
  localparam int N     = ROWS * COLS;
  localparam int CNT_W = $clog2(N + 1);
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  state_t           state_reg;
  logic [CW_W-1:0]  cw_reg  [N];
  logic [MSG_W-1:0] msg_reg [N];
  logic [RES_W-1:0] res_reg [N];
  logic [N-1:0]     err_map_reg;
  logic [N-1:0]     pending_reg;
  logic [CNT_W-1:0] fix_cnt_reg;
  logic             uncorr_reg;
  logic             out_valid_reg;

  logic [CW_W-1:0]  in_lane [N];
  logic [MSG_W-1:0] lane_q  [N];
  logic [RES_W-1:0] lane_r  [N];
  logic [N-1:0]     err_vec;
  logic [CNT_W-1:0] err_cnt;

  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign in_lane[gi] = bus.in_cw[gi*CW_W +: CW_W];
    an_barrett_lane #(.A(A), .CW_W(CW_W), .MSG_W(MSG_W), .RES_W(RES_W)) u_lane (
      .cw (cw_reg[gi]),
      .q  (lane_q[gi]),
      .r  (lane_r[gi])
    );
    assign err_vec[gi] = (lane_r[gi] != '0);
    assign bus.out_msg[gi*MSG_W +: MSG_W] = msg_reg[gi];
  end

  always_comb begin
    err_cnt = '0;
    for (int i = 0; i < N; i++) err_cnt = err_cnt + CNT_W'(err_vec[i]);
  end

  // Shared corrector: lowest-index pending lane wins
  logic [IDX_W-1:0] sel_idx;
  logic [N-1:0]     pending_left;
  syn_t             syn;
  logic [CW_W:0]    err_mag;
  logic [CW_W:0]    cw_fix;
  logic [MSG_W-1:0] fix_q;
  logic [RES_W-1:0] fix_r_unused;
  logic             fix_ok;

  always_comb begin
    sel_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (pending_reg[i]) sel_idx = IDX_W'(i);
    end
    pending_left = pending_reg & ~(N'(1) << sel_idx);
    syn          = syn_lookup(res_reg[sel_idx]);
    err_mag      = (CW_W+1)'(1) << syn.k;
    cw_fix       = syn.neg ? ({1'b0, cw_reg[sel_idx]} + err_mag)
                           : ({1'b0, cw_reg[sel_idx]} - err_mag);
  end

  an_barrett_lane #(.A(A), .CW_W(CW_W), .MSG_W(MSG_W), .RES_W(RES_W)) u_fix (
    .cw (cw_fix[CW_W-1:0]),
    .q  (fix_q),
    .r  (fix_r_unused)
  );

`ifdef AN37_GRID_RANGE_CHECK_EN
  // The extra bit is set both by a borrow below zero and by overflow past 2^CW_W-1
  assign fix_ok = ~cw_fix[CW_W];
`else
  logic cw_fix_msb_unused;
  assign cw_fix_msb_unused = cw_fix[CW_W];
  assign fix_ok = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      err_map_reg   <= '0;
      pending_reg   <= '0;
      fix_cnt_reg   <= '0;
      uncorr_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cw_reg[i]  <= '0;
        msg_reg[i] <= '0;
        res_reg[i] <= '0;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            for (int i = 0; i < N; i++) cw_reg[i] <= in_lane[i];
            state_reg <= LOAD;
          end
        end
        LOAD: begin
          for (int i = 0; i < N; i++) begin
            msg_reg[i] <= lane_q[i];
            res_reg[i] <= lane_r[i];
          end
          err_map_reg <= err_vec;
          fix_cnt_reg <= '0;
          uncorr_reg  <= 1'b0;
          pending_reg <= '0;
          if (err_cnt == '0) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else if (err_cnt > CNT_W'(MAX_FIX)) begin
            uncorr_reg    <= 1'b1;
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end else begin
            pending_reg <= err_vec;
            state_reg   <= FIX;
          end
        end
        FIX: begin
          if (fix_ok) begin
            msg_reg[sel_idx] <= fix_q;
            fix_cnt_reg      <= fix_cnt_reg + CNT_W'(1);
          end else begin
            uncorr_reg <= 1'b1;
          end
          pending_reg <= pending_left;
          if (pending_left == '0) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = rst_n && (state_reg == IDLE);
  assign bus.out_valid   = out_valid_reg;
  assign bus.out_err_map = err_map_reg;
  assign bus.out_fix_cnt = fix_cnt_reg;
  assign bus.out_uncorr  = uncorr_reg;

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    logic [COLS-1:0] bits;
    for (genvar gj = 0; gj < COLS; gj++) begin : g_bit
      assign bits[gj] = err_map_reg[lane_idx(gi, gj, COLS)];
    end
    assign bus.out_row_err[gi] = |bits;
  end

  for (genvar gi = 0; gi < COLS; gi++) begin : g_col
    logic [ROWS-1:0] bits;
    for (genvar gj = 0; gj < ROWS; gj++) begin : g_bit
      assign bits[gj] = err_map_reg[lane_idx(gj, gi, COLS)];
    end
    assign bus.out_col_err[gi] = |bits;
  end
endmodule

// File: tb/tb_an37_grid_seq_decoder.sv
// Directed bench for the AN-37 grid decoder: one task per scenario, inline checks.
module tb_an37_grid_seq_decoder;
  import an37_grid_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;

  logic [CW_W-1:0]  blk     [N];
  logic [MSG_W-1:0] exp_msg [N];

  an37_grid_seq_decoder_if #(.ROWS(ROWS), .COLS(COLS)) bus ();

  an37_grid_seq_decoder #(.ROWS(ROWS), .COLS(COLS), .MAX_FIX(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [MSG_W-1:0] msg_at(input int i);
    return bus.out_msg[i*MSG_W +: MSG_W];
  endfunction

  task automatic load_blk(input logic [CW_W-1:0] v, input logic [MSG_W-1:0] m);
    for (int i = 0; i < N; i++) begin
      blk[i]     = v;
      exp_msg[i] = m;
    end
  endtask

  task automatic drive_blk();
    for (int i = 0; i < N; i++) bus.in_cw[i*CW_W +: CW_W] = blk[i];
  endtask

  // lat counts cycles from the accept cycle (0) to the first cycle with out_valid
  task automatic send_block(output int lat);
    @(negedge clk);
    bus.in_valid = 1'b1;
    drive_blk();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("txn: block sent, out_valid after %0d cycles, fix_cnt=%0d uncorr=%0b map=%h",
             lat, bus.out_fix_cnt, bus.out_uncorr, bus.out_err_map);
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_cw     = '0;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    compared++; if (bus.out_err_map !== 16'h0) begin mismatched++; $display("FAIL reset_map: got %h want 0", bus.out_err_map); end
    compared++; if (bus.out_fix_cnt !== 5'd0) begin mismatched++; $display("FAIL reset_fix_cnt: got %0d want 0", bus.out_fix_cnt); end
    compared++; if (bus.out_msg !== '0) begin mismatched++; $display("FAIL reset_msg: got %h want 0", bus.out_msg); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL post_reset_in_ready: got %b want 1", bus.in_ready); end
    $display("txn: reset released");
  endtask

  task automatic test_clean();
    int lat;
    load_blk(18'd3700, 13'd100);
    send_block(lat);
    compared++; if (lat !== 2) begin mismatched++; $display("FAIL clean_latency: got %0d want 2", lat); end
    for (int i = 0; i < N; i++) begin
      compared++; if (msg_at(i) !== exp_msg[i]) begin mismatched++; $display("FAIL clean_msg lane %0d: got %0d want %0d", i, msg_at(i), exp_msg[i]); end
    end
    compared++; if (bus.out_err_map !== 16'h0) begin mismatched++; $display("FAIL clean_map: got %h want 0", bus.out_err_map); end
    compared++; if (bus.out_fix_cnt !== 5'd0) begin mismatched++; $display("FAIL clean_fix_cnt: got %0d want 0", bus.out_fix_cnt); end
    compared++; if (bus.out_uncorr !== 1'b0) begin mismatched++; $display("FAIL clean_uncorr: got %b want 0", bus.out_uncorr); end
    compared++; if ({bus.out_row_err, bus.out_col_err} !== 8'h00) begin mismatched++; $display("FAIL clean_row_col: got %b want 0", {bus.out_row_err, bus.out_col_err}); end
    compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL clean_in_ready_done: got %b want 0", bus.in_ready); end
    // out_ready was already high when out_valid rose, so the next edge completes the handshake
    @(posedge clk);
    #1;
    compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL clean_release_valid: got %b want 0", bus.out_valid); end
    compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL clean_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_single_fix();
    int lat;
    load_blk(18'd3700, 13'd100);
    blk[5] = 18'd3708;
    send_block(lat);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL single_latency: got %0d want 3", lat); end
    for (int i = 0; i < N; i++) begin
      compared++; if (msg_at(i) !== exp_msg[i]) begin mismatched++; $display("FAIL single_msg lane %0d: got %0d want %0d", i, msg_at(i), exp_msg[i]); end
    end
    compared++; if (bus.out_err_map !== 16'h0020) begin mismatched++; $display("FAIL single_map: got %h want 0020", bus.out_err_map); end
    compared++; if (bus.out_row_err !== 4'b0010) begin mismatched++; $display("FAIL single_row: got %b want 0010", bus.out_row_err); end
    compared++; if (bus.out_col_err !== 4'b0010) begin mismatched++; $display("FAIL single_col: got %b want 0010", bus.out_col_err); end
    compared++; if (bus.out_fix_cnt !== 5'd1) begin mismatched++; $display("FAIL single_fix_cnt: got %0d want 1", bus.out_fix_cnt); end
    compared++; if (bus.out_uncorr !== 1'b0) begin mismatched++; $display("FAIL single_uncorr: got %b want 0", bus.out_uncorr); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_two_fix();
    int lat;
    load_blk(18'd3700, 13'd100);
    blk[0]  = 18'd3696;
    blk[15] = 18'd3708;
    send_block(lat);
    compared++; if (lat !== 4) begin mismatched++; $display("FAIL two_latency: got %0d want 4", lat); end
    for (int i = 0; i < N; i++) begin
      compared++; if (msg_at(i) !== exp_msg[i]) begin mismatched++; $display("FAIL two_msg lane %0d: got %0d want %0d", i, msg_at(i), exp_msg[i]); end
    end
    compared++; if (bus.out_err_map !== 16'h8001) begin mismatched++; $display("FAIL two_map: got %h want 8001", bus.out_err_map); end
    compared++; if (bus.out_row_err !== 4'b1001) begin mismatched++; $display("FAIL two_row: got %b want 1001", bus.out_row_err); end
    compared++; if (bus.out_col_err !== 4'b1001) begin mismatched++; $display("FAIL two_col: got %b want 1001", bus.out_col_err); end
    compared++; if (bus.out_fix_cnt !== 5'd2) begin mismatched++; $display("FAIL two_fix_cnt: got %0d want 2", bus.out_fix_cnt); end
    compared++; if (bus.out_uncorr !== 1'b0) begin mismatched++; $display("FAIL two_uncorr: got %b want 0", bus.out_uncorr); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_over_max();
    int lat;
    load_blk(18'd3700, 13'd100);
    blk[1]  = 18'd3696; exp_msg[1] = 13'd99;
    blk[6]  = 18'd3696; exp_msg[6] = 13'd99;
    blk[11] = 18'd3732; exp_msg[11] = 13'd100;
    send_block(lat);
    compared++; if (lat !== 2) begin mismatched++; $display("FAIL over_latency: got %0d want 2", lat); end
    for (int i = 0; i < N; i++) begin
      compared++; if (msg_at(i) !== exp_msg[i]) begin mismatched++; $display("FAIL over_msg lane %0d: got %0d want %0d", i, msg_at(i), exp_msg[i]); end
    end
    compared++; if (bus.out_err_map !== 16'h0842) begin mismatched++; $display("FAIL over_map: got %h want 0842", bus.out_err_map); end
    compared++; if (bus.out_row_err !== 4'b0111) begin mismatched++; $display("FAIL over_row: got %b want 0111", bus.out_row_err); end
    compared++; if (bus.out_col_err !== 4'b1110) begin mismatched++; $display("FAIL over_col: got %b want 1110", bus.out_col_err); end
    compared++; if (bus.out_fix_cnt !== 5'd0) begin mismatched++; $display("FAIL over_fix_cnt: got %0d want 0", bus.out_fix_cnt); end
    compared++; if (bus.out_uncorr !== 1'b1) begin mismatched++; $display("FAIL over_uncorr: got %b want 1", bus.out_uncorr); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    int lat;
    bus.out_ready = 1'b0;
    load_blk(18'd3700, 13'd100);
    blk[5] = 18'd3708;
    send_block(lat);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL bp_latency: got %0d want 3", lat); end
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_cw    = '1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      $display("txn: stall cycle %0d valid=%b in_ready=%b", c, bus.out_valid, bus.in_ready);
      compared++; if (bus.out_valid !== 1'b1) begin mismatched++; $display("FAIL bp_valid cyc %0d: got %b want 1", c, bus.out_valid); end
      compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL bp_in_ready cyc %0d: got %b want 0", c, bus.in_ready); end
      compared++; if (msg_at(5) !== 13'd100) begin mismatched++; $display("FAIL bp_msg5 cyc %0d: got %0d want 100", c, msg_at(5)); end
      compared++; if (bus.out_fix_cnt !== 5'd1) begin mismatched++; $display("FAIL bp_fix_cnt cyc %0d: got %0d want 1", c, bus.out_fix_cnt); end
      compared++; if (bus.out_err_map !== 16'h0020) begin mismatched++; $display("FAIL bp_map cyc %0d: got %h want 0020", c, bus.out_err_map); end
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL bp_release_valid: got %b want 0", bus.out_valid); end
    compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL bp_release_ready: got %b want 1", bus.in_ready); end
  endtask

  task automatic test_reset_mid();
    int lat;
    load_blk(18'd3700, 13'd100);
    blk[0]  = 18'd3696;
    blk[15] = 18'd3708;
    @(negedge clk);
    bus.in_valid = 1'b1;
    drive_blk();
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    $display("txn: reset asserted during correction");
    compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_valid: got %b want 0", bus.out_valid); end
    compared++; if (bus.in_ready !== 1'b0) begin mismatched++; $display("FAIL mid_in_ready: got %b want 0", bus.in_ready); end
    compared++; if (bus.out_err_map !== 16'h0) begin mismatched++; $display("FAIL mid_map: got %h want 0", bus.out_err_map); end
    compared++; if (bus.out_fix_cnt !== 5'd0) begin mismatched++; $display("FAIL mid_fix_cnt: got %0d want 0", bus.out_fix_cnt); end
    compared++; if (msg_at(0) !== 13'd0) begin mismatched++; $display("FAIL mid_msg0: got %0d want 0", msg_at(0)); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compared++; if (bus.in_ready !== 1'b1) begin mismatched++; $display("FAIL mid_release_ready: got %b want 1", bus.in_ready); end
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      compared++; if (bus.out_valid !== 1'b0) begin mismatched++; $display("FAIL mid_no_partial cyc %0d: got %b want 0", c, bus.out_valid); end
    end
    load_blk(18'd3700, 13'd100);
    blk[3] = 18'd3716;
    send_block(lat);
    compared++; if (lat !== 3) begin mismatched++; $display("FAIL after_latency: got %0d want 3", lat); end
    for (int i = 0; i < N; i++) begin
      compared++; if (msg_at(i) !== exp_msg[i]) begin mismatched++; $display("FAIL after_msg lane %0d: got %0d want %0d", i, msg_at(i), exp_msg[i]); end
    end
    compared++; if (bus.out_err_map !== 16'h0008) begin mismatched++; $display("FAIL after_map: got %h want 0008", bus.out_err_map); end
    compared++; if (bus.out_fix_cnt !== 5'd1) begin mismatched++; $display("FAIL after_fix_cnt: got %0d want 1", bus.out_fix_cnt); end
    compared++; if (bus.out_uncorr !== 1'b0) begin mismatched++; $display("FAIL after_uncorr: got %b want 0", bus.out_uncorr); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset();
    test_clean();
    test_single_fix();
    test_two_fix();
    test_over_max();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end
endmodule
